// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and helpers for the D-cache fill/store controller.
package cache_fill_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DONE  = 2'd2,
        WRITE = 2'd3
    } state_t;

    function automatic int offset_bits(input int words_per_line);
        return $clog2(words_per_line * 2);
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_line_addr_gen.sv
// Line base / word counter and the one-stage memory-to-cache write pipeline.
module line_addr_gen
    import cache_fill_ctrl_pkg::*;
#(
    parameter int DWIDTH         = 16,
    parameter int AWIDTH         = 16,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              advance,
    input  logic [AWIDTH-1:0] miss_addr,
    input  logic [DWIDTH-1:0] rd_data,
    output logic [AWIDTH-1:0] first_addr,
    output logic [AWIDTH-1:0] nxt_addr,
    output logic              last,
    output logic              cache_wr_en,
    output logic [AWIDTH-1:0] cache_wr_addr,
    output logic [DWIDTH-1:0] cache_wr_data
);

    localparam int CW = $clog2(WORDS_PER_LINE);
    localparam int OB = offset_bits(WORDS_PER_LINE);

    logic [AWIDTH-1:0] line_base;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_inc;
    logic [AWIDTH-1:0] rd_addr;
    logic              unused_low;

    assign unused_low = ^miss_addr[OB-1:0];
    assign cnt_inc    = cnt + CW'(1);

    // Offsets live entirely in the cleared low bits, so OR never carries out.
    assign first_addr = {miss_addr[AWIDTH-1:OB], {OB{1'b0}}};
    assign rd_addr    = line_base | AWIDTH'({cnt, 1'b0});
    assign nxt_addr   = line_base | AWIDTH'({cnt_inc, 1'b0});
    assign last       = (cnt == CW'(WORDS_PER_LINE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            line_base     <= '0;
            cnt           <= '0;
            cache_wr_en   <= 1'b0;
            cache_wr_addr <= '0;
            cache_wr_data <= '0;
        end else begin
            if (start) begin
                line_base <= first_addr;
                cnt       <= '0;
            end else if (advance) begin
                cnt <= cnt_inc;
            end
            cache_wr_en <= advance;
            if (advance) begin
                cache_wr_addr <= rd_addr;
                cache_wr_data <= rd_data;
            end
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// D-cache line-fill and write-through store controller for a 16-bit
// single-cycle data memory; reads and writes are never issued together.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int DWIDTH         = 16,
    parameter int AWIDTH         = 16,
    parameter int WORDS_PER_LINE = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss_detected,
    input  logic [AWIDTH-1:0] miss_addr,
    input  logic              st_req,
    input  logic [AWIDTH-1:0] st_addr,
    input  logic [DWIDTH-1:0] st_data,
    output logic              st_ack,
    output logic              busy,
    output logic              fill_done,
    output logic              cache_wr_en,
    output logic [AWIDTH-1:0] cache_wr_addr,
    output logic [DWIDTH-1:0] cache_wr_data,
    output logic              mem_enable,
    output logic              mem_wr,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_data_in,
    input  logic [DWIDTH-1:0] mem_data_out
);

    state_t            state;
    logic              start;
    logic              advance;
    logic              last;
    logic [AWIDTH-1:0] first_addr;
    logic [AWIDTH-1:0] nxt_addr;
    logic              unused_st;

    assign unused_st = st_addr[0];
    assign start     = (state == IDLE) && !st_req && miss_detected;
    assign advance   = (state == FILL);

    line_addr_gen #(
        .DWIDTH        (DWIDTH),
        .AWIDTH        (AWIDTH),
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_gen (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .advance      (advance),
        .miss_addr    (miss_addr),
        .rd_data      (mem_data_out),
        .first_addr   (first_addr),
        .nxt_addr     (nxt_addr),
        .last         (last),
        .cache_wr_en  (cache_wr_en),
        .cache_wr_addr(cache_wr_addr),
        .cache_wr_data(cache_wr_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            st_ack      <= 1'b0;
            busy        <= 1'b0;
            fill_done   <= 1'b0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            st_ack      <= 1'b0;
            fill_done   <= 1'b0;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            unique case (state)
                IDLE: begin
                    // Store first so a following fill sees the new word.
                    if (st_req) begin
                        state       <= WRITE;
                        busy        <= 1'b1;
                        st_ack      <= 1'b1;
                        mem_enable  <= 1'b1;
                        mem_wr      <= 1'b1;
                        mem_addr    <= {st_addr[AWIDTH-1:1], 1'b0};
                        mem_data_in <= st_data;
                    end else if (miss_detected) begin
                        state      <= FILL;
                        busy       <= 1'b1;
                        mem_enable <= 1'b1;
                        mem_addr   <= first_addr;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                FILL: begin
                    busy <= 1'b1;
                    if (last) begin
                        state     <= DONE;
                        fill_done <= 1'b1;
                    end else begin
                        mem_enable <= 1'b1;
                        mem_addr   <= nxt_addr;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                WRITE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
